ahbl_arbiter: RTL

// AHB-lite N:1 arbiter: N upstream masters share one downstream master port (slave/splitter).

---
 rtl/ahbl_arbiter.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ahbl_arbiter.sv
// AHB-lite N:1 fixed-priority arbiter (port 0 highest). Requests that lose arbitration or arrive
// during a downstream stall are parked in a per-port buffer while that master's data phase is held.
module ahbl_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned W_ADDR  = 32,
  parameter int unsigned W_DATA  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic [N_PORTS-1:0]        src_hready,
  output logic [N_PORTS-1:0]        src_hready_resp,
  output logic [N_PORTS-1:0]        src_hresp,
  output logic [N_PORTS-1:0]        src_hexokay,
  input  logic [N_PORTS*W_ADDR-1:0] src_haddr,
  input  logic [N_PORTS-1:0]        src_hwrite,
  input  logic [N_PORTS*2-1:0]      src_htrans,
  input  logic [N_PORTS*3-1:0]      src_hsize,
  input  logic [N_PORTS*3-1:0]      src_hburst,
  input  logic [N_PORTS*4-1:0]      src_hprot,
  input  logic [N_PORTS*4-1:0]      src_hmaster,
  input  logic [N_PORTS-1:0]        src_hmastlock,
  input  logic [N_PORTS-1:0]        src_hexcl,
  input  logic [N_PORTS*W_DATA-1:0] src_hwdata,
  output logic [N_PORTS*W_DATA-1:0] src_hrdata,

  output logic                      dst_hready,
  input  logic                      dst_hready_resp,
  input  logic                      dst_hresp,
  input  logic                      dst_hexokay,
  output logic [W_ADDR-1:0]         dst_haddr,
  output logic                      dst_hwrite,
  output logic [1:0]                dst_htrans,
  output logic [2:0]                dst_hsize,
  output logic [2:0]                dst_hburst,
  output logic [3:0]                dst_hprot,
  output logic [3:0]                dst_hmaster,
  output logic                      dst_hmastlock,
  output logic                      dst_hexcl,
  output logic [W_DATA-1:0]         dst_hwdata,
  input  logic [W_DATA-1:0]         dst_hrdata
);

  typedef struct packed {
    logic [W_ADDR-1:0] addr;
    logic              write;
    logic [2:0]        size;
    logic [3:0]        prot;
    logic [3:0]        master;
    logic              mastlock;
    logic              excl;
  } addr_t;

  addr_t              live_a [N_PORTS];
  addr_t              src_a  [N_PORTS];
  addr_t              buf_q  [N_PORTS];
  addr_t              buf_d  [N_PORTS];
  addr_t              sel_a;
  logic [N_PORTS-1:0] buf_valid_q, buf_valid_d;
  logic [N_PORTS-1:0] dphase_sel_q, dphase_sel_d;
  logic [N_PORTS-1:0] gnt_hold_q;
  logic               hold_q, hold_d;
  logic [N_PORTS-1:0] live, eff_req, gnt_lo, grant;
  logic               found;
  logic [N_PORTS-1:0] unused_htrans_lsb;
  logic               unused_burst;

  // BUSY (2'b01) is treated as IDLE, and bursts are flattened, so these bits are never consulted.
  assign unused_burst = ^src_hburst;

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      live_a[i].addr     = src_haddr[i*W_ADDR +: W_ADDR];
      live_a[i].write    = src_hwrite[i];
      live_a[i].size     = src_hsize[i*3 +: 3];
      live_a[i].prot     = src_hprot[i*4 +: 4];
      live_a[i].master   = src_hmaster[i*4 +: 4];
      live_a[i].mastlock = src_hmastlock[i];
      live_a[i].excl     = src_hexcl[i];
      live[i]            = src_hready[i] & src_htrans[2*i+1] & ~buf_valid_q[i];
      unused_htrans_lsb[i] = src_htrans[2*i];
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      src_a[i] = buf_valid_q[i] ? buf_q[i] : live_a[i];
    end
  end

  assign eff_req = buf_valid_q | live;

  always_comb begin
    gnt_lo = '0;
    found  = 1'b0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (eff_req[i] && !found) begin
        gnt_lo[i] = 1'b1;
        found     = 1'b1;
      end
    end
  end

  // While a downstream wait state is pending the issued address must not change owner.
  assign grant = hold_q ? gnt_hold_q : gnt_lo;

  always_comb begin
    sel_a = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i]) sel_a = addr_t'(sel_a | src_a[i]);
    end
  end

  assign dst_hready    = dst_hready_resp;
  assign dst_haddr     = sel_a.addr;
  assign dst_hwrite    = sel_a.write;
  assign dst_hsize     = sel_a.size;
  assign dst_hprot     = sel_a.prot;
  assign dst_hmaster   = sel_a.master;
  assign dst_hmastlock = sel_a.mastlock;
  assign dst_hexcl     = sel_a.excl;
  assign dst_htrans    = (|grant) ? 2'b10 : 2'b00;
  assign dst_hburst    = 3'b000;

  always_comb begin
    dst_hwdata = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (dphase_sel_q[i]) dst_hwdata = dst_hwdata | src_hwdata[i*W_DATA +: W_DATA];
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      src_hready_resp[i]            = buf_valid_q[i] ? 1'b0 :
                                      dphase_sel_q[i] ? dst_hready_resp : 1'b1;
      src_hresp[i]                  = dphase_sel_q[i] & dst_hresp;
      src_hexokay[i]                = dphase_sel_q[i] & dst_hexokay;
      src_hrdata[i*W_DATA +: W_DATA] = dst_hrdata;
    end
  end

  always_comb begin
    buf_valid_d  = buf_valid_q;
    dphase_sel_d = dphase_sel_q;
    buf_d        = buf_q;
    hold_d       = dst_htrans[1] & ~dst_hready;
    if (dst_hready) dphase_sel_d = grant;
    for (int i = 0; i < N_PORTS; i++) begin
      if (grant[i] && dst_hready) begin
        buf_valid_d[i] = 1'b0;
      end else if (live[i]) begin
        buf_valid_d[i] = 1'b1;
        buf_d[i]       = live_a[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q  <= '0;
      dphase_sel_q <= '0;
      gnt_hold_q   <= '0;
      hold_q       <= 1'b0;
      for (int i = 0; i < N_PORTS; i++) buf_q[i] <= '0;
    end else begin
      buf_valid_q  <= buf_valid_d;
      dphase_sel_q <= dphase_sel_d;
      gnt_hold_q   <= grant;
      hold_q       <= hold_d;
      for (int i = 0; i < N_PORTS; i++) buf_q[i] <= buf_d[i];
    end
  end

endmodule
